// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller with shadowed digit data,
// per-digit enable/blink, leading-zero blanking, PWM dimming and registered pins.
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 50000,
    parameter int BLINK_W    = 25,
    parameter int DUTY_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [DUTY_W-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BLINK_W-1:0]      blink_q, blink_d;
    logic [DUTY_W-1:0]       duty_q, duty_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              sseg_q, sseg_d;

    logic                    tick;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              cur_hex;
    logic [6:0]              cur_seg;
    logic                    lit_pwm;
    logic                    blank;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    // A digit is a leading zero when it and every higher digit hold zero.
    assign lz[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lz[gi] = lz_blank & ~|hex_q[4*NUM_DIGITS-1:4*gi];
        end
    endgenerate

    assign tick    = (presc_q == PW'(DIV - 1));
    assign cur_hex = hex_q[{idx_q, 2'b00} +: 4];
    assign cur_seg = decode(cur_hex);
    assign lit_pwm = (&brightness) | (duty_q < brightness);
    assign blank   = ~digit_en[idx_q] | (blink_q[BLINK_W-1] & blink_mask[idx_q])
                   | lz[idx_q] | ~lit_pwm;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        blink_d = blink_q + 1'b1;
        duty_d  = duty_q + 1'b1;
        hex_d   = load ? hex_in : hex_q;
        dp_d    = load ? dp_in : dp_q;
        an_d    = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        sseg_d  = blank ? 8'hFF : {~dp_q[idx_q], cur_seg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            duty_q  <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            an_q    <= '1;
            sseg_q  <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            duty_q  <= duty_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed scenarios plus random traffic, checked every
// cycle against a time-based behavioural model of the scan.
module tb_sseg_scan_ctrl;

    localparam int N   = 4;
    localparam int DV  = 4;
    localparam int BW  = 4;
    localparam int DW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           load;
    logic [4*N-1:0] hex_in;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   digit_en;
    logic [N-1:0]   blink_mask;
    logic           lz_blank;
    logic [DW-1:0]  brightness;
    logic [N-1:0]   an;
    logic [7:0]     sseg;

    int checks = 0;
    int errors = 0;
    int c;                      // clock edges since reset release
    logic [4*N-1:0] sh_hex;
    logic [N-1:0]   sh_dp;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    sseg_scan_ctrl #(
        .NUM_DIGITS(N), .DIV(DV), .BLINK_W(BW), .DUTY_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in),
        .digit_en(digit_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .brightness(brightness), .an(an), .sseg(sseg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Pin values produced by the edge that follows cycle number cc.
    function automatic logic [N+7:0] model(input int cc);
        int  idx, hi, hx, duty;
        bit  blink_ph, lit, lz, blank;
        idx      = (cc / DV) % N;
        blink_ph = ((cc % (1 << BW)) >= (1 << (BW - 1)));
        duty     = cc % (1 << DW);
        lit      = (brightness == (1 << DW) - 1) || (duty < brightness);
        hi = -1;
        for (int j = 0; j < N; j++) if (sh_hex[4*j +: 4] != 0) hi = j;
        lz    = lz_blank && (idx > 0) && (idx > hi);
        blank = !digit_en[idx] || (blink_ph && blink_mask[idx]) || lz || !lit;
        hx    = sh_hex[4*idx +: 4];
        if (blank) return {{N{1'b1}}, 8'hFF};
        return {~(N'(1) << idx), ~sh_dp[idx], seg_tab[hx]};
    endfunction

    task automatic cyc();
        logic [N+7:0] exp;
        exp = model(c);
        @(posedge clk);
        if (load) begin
            sh_hex = hex_in;
            sh_dp  = dp_in;
        end
        c++;
        #1;
        $display("cyc %0d an=%b sseg=%b exp_an=%b exp_sseg=%b", c, an, sseg, exp[N+7:8], exp[7:0]);
        chk("an", 32'(an), 32'(exp[N+7:8]));
        chk("sseg", 32'(sseg), 32'(exp[7:0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load_pulse(input logic [4*N-1:0] h, input logic [N-1:0] d);
        hex_in = h;
        dp_in  = d;
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0;
        digit_en = '1; blink_mask = '0; lz_blank = 1'b0; brightness = '1;
        c = 0; sh_hex = '0; sh_dp = '0;
        #1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_sseg", 32'(sseg), 32'hFF);
        #11 reset = 1'b0;

        // Basic scan of 1234, then non-loaded input change, then a reload
        load_pulse(16'h1234, 4'b0000);
        run(40);
        hex_in = 16'hFFFF; dp_in = 4'b1111;
        run(16);
        load_pulse(16'h89AB, 4'b0101);
        run(16);

        // Leading-zero blanking
        lz_blank = 1'b1;
        load_pulse(16'h0050, 4'b1000);
        run(16);
        load_pulse(16'h0000, 4'b0000);
        run(16);
        lz_blank = 1'b0;
        load_pulse(16'hC0DE, 4'b0010);

        // Blink on digit 0
        blink_mask = 4'b0001;
        run(32);
        blink_mask = 4'b0000;

        // PWM brightness levels
        brightness = 2'd1; run(16);
        brightness = 2'd0; run(16);
        brightness = 2'd2; run(16);
        brightness = 2'd3; run(8);

        // Reset mid-slot: blanks without waiting for an edge, scan restarts at digit 0
        run(2);
        #2 reset = 1'b1;
        #1;
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_sseg", 32'(sseg), 32'hFF);
        @(posedge clk); #1;
        chk("hold_an", 32'(an), 32'hF);
        #2 reset = 1'b0;
        c = 0; sh_hex = '0; sh_dp = '0;
        run(8);

        // Random traffic, including loads landing on tick cycles
        for (int i = 0; i < 600; i++) begin
            hex_in     = 16'($urandom);
            dp_in      = 4'($urandom);
            load       = ($urandom_range(0, 5) == 0);
            digit_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            blink_mask = 4'($urandom);
            lz_blank   = 1'($urandom);
            brightness = 2'($urandom);
            if ($urandom_range(0, 3) == 0) hex_in[15:8] = 8'h00;
            cyc();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
